// File: rtl/timer_device_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL field positions, mode codes and FSM state encodings.
package timer_device_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IM = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  // Only 01 reloads; the reserved codes 10/11 fall back to one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD) && (mode != MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/timer_device.sv
// Programmable countdown timer on the system bridge; raises IRQ on expiry,
// latched in one-shot mode or as a one-cycle pulse in auto-reload mode.
module timer_device #(
  parameter logic [31:0] PRESET_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Addr,
  input  logic        Write_Enabled,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        IRQ
);
  import timer_device_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;

  logic unused_data_in_hi;
  assign unused_data_in_hi = ^Data_In[31:4];

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d   = 32'd0;
          pending_d = 1'b1;
          state_d   = S_INT;
        end
      end
      S_INT: begin
        if (is_reload(ctrl_q[2:1])) begin
          pending_d = 1'b0;
          state_d   = S_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes come last so software beats the hardware Enable clear and expiry.
    if (Write_Enabled) begin
      case (Addr)
        ADDR_CTRL: begin
          ctrl_d    = Data_In[3:0];
          pending_d = 1'b0;
        end
        ADDR_PRESET: preset_d = Data_In;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 4'b0;
      preset_q  <= PRESET_RESET;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    Data_Out = 32'd0;
    case (Addr)
      ADDR_CTRL:   Data_Out = {28'd0, ctrl_q};
      ADDR_PRESET: Data_Out = preset_q;
      ADDR_COUNT:  Data_Out = count_q;
      default:     Data_Out = 32'd0;
    endcase
  end

  assign IRQ = pending_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against Data_Out and IRQ.
module tb_timer_device;

  localparam logic [31:0] TB_PRESET_RESET = 32'h0000_0007;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int cyc;
  int checks;
  int errors;

  typedef struct {
    int          cyc;
    string       name;
    logic        chk_data;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  timer_device #(.PRESET_RESET(TB_PRESET_RESET)) dut (
    .clk           (clk),
    .rst           (rst),
    .Addr          (addr),
    .Write_Enabled (we),
    .Data_In       (din),
    .Data_Out      (dout),
    .IRQ           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives the bus inputs that the coming clock edge will act on.
  task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
    we   = w;
    addr = a;
    din  = d;
  endtask

  // Queues what Data_Out/IRQ must show during the current cycle.
  task automatic checkOutput(input string name, input logic chk, input logic [31:0] d,
                             input logic i);
    exp_t e;
    e.cyc      = cyc;
    e.name     = name;
    e.chk_data = chk;
    e.data     = d;
    e.irq      = i;
    sb.push_back(e);
  endtask

  task automatic cy(input logic w, input logic [1:0] a, input logic [31:0] d,
                    input logic chk, input logic [31:0] ed, input logic ei, input string name);
    applyStimulus(w, a, d);
    checkOutput(name, chk, ed, ei);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expectation tagged with the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                 e.name, e.cyc, cyc);
      end else begin
        if (e.chk_data) begin
          checks++;
          if (dout !== e.data) begin
            errors++;
            $display("[TB] FAIL %s data: got %h expected %h (cycle %0d)",
                     e.name, dout, e.data, cyc);
          end
        end
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("[TB] FAIL %s irq: got %b expected %b (cycle %0d)", e.name, irq, e.irq, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Hand-derived per-cycle COUNT/IRQ traces starting at the CTRL-write edge.
  logic [31:0] os_count [8]  = '{0, 0, 5, 4, 3, 2, 1, 0};
  logic [31:0] ar_count [13] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
  logic        ar_irq   [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
  logic [31:0] mk_count [5]  = '{2, 2, 2, 1, 0};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    cy(0, 2'd0, 0, 1, 32'd0, 0, "rst_ctrl");
    cy(0, 2'd1, 0, 1, TB_PRESET_RESET, 0, "rst_preset");
    cy(0, 2'd2, 0, 1, 32'd0, 0, "rst_count");
    cy(0, 2'd3, 0, 1, 32'd0, 0, "addr3_zero");

    // One-shot, PRESET=5, IM+Enable
    cy(1, 2'd1, 5, 1, TB_PRESET_RESET, 0, "os_preset_wr");
    cy(1, 2'd0, 32'h9, 1, 32'd0, 0, "os_ctrl_wr");
    for (int k = 0; k < 7; k++) cy(0, 2'd2, 0, 1, os_count[k], 0, "os_count");
    cy(0, 2'd2, 0, 1, os_count[7], 1, "os_expire");
    cy(0, 2'd0, 0, 1, 32'h8, 1, "os_ctrl_en_cleared");
    cy(1, 2'd0, 32'h0, 1, 32'h8, 1, "os_irq_latched");
    cy(0, 2'd0, 0, 1, 32'h0, 0, "os_irq_cleared");

    // Auto-reload, PRESET=3: pulse every 5 cycles
    cy(1, 2'd1, 3, 1, 32'd5, 0, "ar_preset_wr");
    cy(1, 2'd0, 32'hB, 1, 32'd0, 0, "ar_ctrl_wr");
    for (int k = 0; k < 12; k++) cy(0, 2'd2, 0, 1, ar_count[k], ar_irq[k], "ar_trace");
    cy(1, 2'd0, 32'h0, 1, 32'hB, ar_irq[12], "ar_disable_wr");
    cy(0, 2'd2, 0, 1, 32'd2, 0, "ar_last_dec");
    cy(0, 2'd2, 0, 1, 32'd2, 0, "ar_idle_hold");

    // Masked one-shot, PRESET=2
    cy(1, 2'd1, 2, 1, 32'd3, 0, "mk_preset_wr");
    cy(1, 2'd0, 32'h1, 1, 32'd0, 0, "mk_ctrl_wr");
    for (int k = 0; k < 5; k++) cy(0, 2'd2, 0, 1, mk_count[k], 0, "mk_count");
    cy(1, 2'd0, 32'h8, 1, 32'h0, 0, "mk_ctrl_cleared");
    cy(0, 2'd0, 0, 1, 32'h8, 0, "mk_unmask_lost");

    // Disable mid-count at COUNT=6, then re-enable
    cy(1, 2'd1, 10, 1, 32'd2, 0, "dis_preset_wr");
    cy(1, 2'd0, 32'h9, 1, 32'h8, 0, "dis_ctrl_wr");
    cy(0, 2'd2, 0, 1, 32'd0, 0, "dis_idle");
    cy(0, 2'd2, 0, 1, 32'd0, 0, "dis_load");
    cy(0, 2'd2, 0, 1, 32'd10, 0, "dis_c10");
    cy(0, 2'd2, 0, 1, 32'd9, 0, "dis_c9");
    cy(0, 2'd2, 0, 1, 32'd8, 0, "dis_c8");
    cy(1, 2'd0, 32'h8, 1, 32'h9, 0, "dis_en_clear_wr");
    for (int k = 0; k < 4; k++) cy(0, 2'd2, 0, 1, 32'd6, 0, "dis_hold6");
    cy(1, 2'd0, 32'h9, 1, 32'h8, 0, "dis_reenable_wr");
    cy(0, 2'd2, 0, 1, 32'd6, 0, "re_idle");
    cy(0, 2'd2, 0, 1, 32'd6, 0, "re_load");
    for (int v = 10; v >= 1; v--) cy(0, 2'd2, 0, 1, v, 0, "re_count");

    // Collision: CTRL write during the one-shot INT cycle
    cy(1, 2'd0, 32'h9, 1, 32'h9, 1, "col_int_wr");
    cy(0, 2'd0, 0, 1, 32'h9, 0, "col_ctrl_kept");
    cy(0, 2'd2, 0, 1, 32'd0, 0, "col_load");
    cy(0, 2'd2, 0, 1, 32'd10, 0, "col_new_count");

    // Reset mid-count
    rst = 1'b1;
    cy(0, 2'd2, 0, 1, 32'd9, 0, "mid_count");
    rst = 1'b0;
    cy(0, 2'd2, 0, 1, 32'd0, 0, "rst2_count");
    cy(0, 2'd0, 0, 1, 32'd0, 0, "rst2_ctrl");

    // PRESET=0 behaves like PRESET=1
    cy(1, 2'd1, 0, 1, TB_PRESET_RESET, 0, "z_preset_wr");
    cy(1, 2'd0, 32'h9, 1, 32'd0, 0, "z_ctrl_wr");
    cy(0, 2'd2, 0, 1, 32'd0, 0, "z_idle");
    cy(0, 2'd2, 0, 1, 32'd0, 0, "z_load");
    cy(0, 2'd2, 0, 1, 32'd0, 0, "z_cnt");
    cy(0, 2'd2, 0, 1, 32'd0, 1, "z_expire");

    applyStimulus(1'b0, 2'd0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("[TB] FAIL scoreboard: %0d expectations left unchecked", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped programmable countdown timer on the system bridge.
- Drives one bit of the coprocessor's Hardware_Interruption[15:10] vector, so it is the interrupt-source end of the interrupt interface.
- Software programs PRESET and CTRL through word-addressed registers.
- On count expiry the block raises IRQ, either latched (one-shot) or as a single-cycle pulse (auto-reload).

Parameters:
- PRESET_RESET, 32'h0, reset value of the PRESET register.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- Addr  input  2  word select (byte address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
- Write_Enabled  input  1  bus write strobe for the selected register.
- Data_In  input  32  write data.
- Data_Out  output  32  read data, combinational from Addr.
- IRQ  output  1  interrupt request to the coprocessor hardware-interrupt input.

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high; all state updates on posedge clk.
- Reset: CTRL=0, PRESET=PRESET_RESET, COUNT=0, state=IDLE, pending=0, IRQ=0. Data_Out then follows the reset register contents.
- CTRL fields:
  - [0] Enable.
  - [2:1] Mode: 00 one-shot, 01 auto-reload, 10/11 behave as 00.
  - [3] IM, interrupt mask.
  - [31:4] read as 0.
- Reads (combinational):
  - Addr 0: {28'b0, CTRL[3:0]}.
  - Addr 1: PRESET.
  - Addr 2: COUNT.
  - Addr 3: 32'b0.
- Writes, on a cycle with Write_Enabled=1:
  - Addr 0: CTRL[3:0] <= Data_In[3:0] and pending <= 0.
  - Addr 1: PRESET <= Data_In. The count in progress is unaffected; the new value is used at the next LOAD.
  - Addr 2/3: ignored (COUNT is read-only).
- IRQ = pending & CTRL[3]. Registered, no combinational path from bus inputs.
- FSM states: IDLE, LOAD, CNT, INT. The FSM evaluates register values from before the current edge; a CTRL write is seen the next cycle.
  - IDLE: Enable=1 -> LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET -> CNT. Goes to CNT regardless of Enable; CNT handles disable.
  - CNT:
    - Enable=0 -> IDLE, COUNT holds.
    - Else if COUNT>1: COUNT <= COUNT-1, stay.
    - Else (COUNT is 0 or 1): COUNT <= 0, pending <= 1, -> INT.
  - INT, Mode 01: pending <= 0 (one-cycle pulse), -> LOAD.
  - INT, other modes: hardware clears CTRL[0], pending stays 1, -> IDLE.
- Latency: with PRESET=N≥1, Enable written at edge t gives pending=1 after edge t+N+2. N=0 behaves as N=1.
- Auto-reload period: N+2 cycles between pulses.
- Simultaneous events:
  - CTRL write in the same cycle as the INT-state hardware clear of Enable: the software write wins for CTRL[3:0] and for pending.
  - CTRL write in the cycle CNT expires: pending ends 0 (write wins); the FSM still enters INT.
- Disable mid-count: IDLE with COUNT frozen. Re-enable reloads from PRESET; no resume.
- Unmask with pending latched: IRQ rises the cycle after the IM write only if that write does not clear pending. Any CTRL write clears pending, so the latched interrupt is lost and software must re-arm.
- Reset mid-count or while IRQ is high: everything returns to reset values at that edge.
- Arithmetic: 32-bit unsigned; COUNT never wraps below 0.

Decomposition:
- Shared package holds:
  - register offsets ADDR_CTRL=2'd0, ADDR_PRESET=2'd1, ADDR_COUNT=2'd2;
  - mode constants MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01;
  - 2-bit state encodings S_IDLE/S_LOAD/S_CNT/S_INT;
  - CTRL bit indices for Enable and IM.
- No sub-module: register file, FSM and decrementer together sit well under 200 lines in a single module.

Test Plan:
- Reset: assert rst one cycle -> Data_Out reads 0 at Addr 0 and 2, PRESET_RESET at Addr 1; IRQ=0.
- One-shot: PRESET=5, then CTRL=4'b1001 at edge t -> IRQ rises after edge t+7 and stays high; CTRL reads 4'b1000. Then write CTRL=0 -> IRQ=0 the next cycle.
- Auto-reload: PRESET=3, CTRL=4'b1011 -> IRQ one-cycle pulses every 5 cycles; COUNT sequence 3,2,1,0,(LOAD)3...
- Mask: PRESET=2, CTRL=4'b0001 -> pending set, IRQ stays 0 throughout; COUNT reaches 0; CTRL reads 4'b0000.
- Disable mid-count: PRESET=10, enable, clear Enable when COUNT=6 -> COUNT holds 6 and IRQ never rises. Re-enable -> COUNT reloads 10.
- Collision: write CTRL=4'b1001 in the same cycle the FSM is in INT (one-shot) -> CTRL ends 4'b1001, pending=0, FSM goes to IDLE then LOAD and starts a new count.
